// File: rtl/mtm_alu_serializer_if.sv
// Handshake bundle between the ALU core (master) and the sout serializer (slave).
interface mtm_alu_serializer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_err;
  logic [31:0] in_c;
  logic [3:0]  in_flags;
  logic [2:0]  in_err;

  modport master (
    output in_valid, in_is_err, in_c, in_flags, in_err,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_is_err, in_c, in_flags, in_err,
    output in_ready
  );
endinterface

// File: rtl/mtm_alu_serializer.sv
// mtm_Alu output serializer: frames a result (5 packets) or an error (1 packet) into 11-bit packets on sout.
// Build option MTM_SOUT_IDLE_GAP_EN inserts GAP_BITS idle-high bit-periods between result packets.
module mtm_alu_serializer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 2
) (
  input  logic                clk,
  input  logic                rst,
  mtm_alu_serializer_if.slave in_if,
  output logic                sout,
  output logic                busy
);
  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam bit            PARAMS_OK = (CLKS_PER_BIT >= 1) && (GAP_BITS >= 0);
`ifdef MTM_SOUT_IDLE_GAP_EN
  localparam int            GW        = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_BITS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // CRC3, x^3+x+1, init 000, over {C, 1'b0, flags} MSB first
  function automatic logic [2:0] crc3_f(input logic [31:0] c, input logic [3:0] flags);
    logic [36:0] msg;
    logic [2:0]  crc;
    logic        fb;
    msg = {c, 1'b0, flags};
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  function automatic logic [7:0] payload_f(input logic is_err, input logic [2:0] pkt,
                                           input logic [31:0] c, input logic [3:0] flags,
                                           input logic [2:0] crc, input logic [2:0] err);
    logic [7:0] p;
    if (is_err) begin
      p = {1'b1, err, err, ^{1'b1, err, err}};
    end else begin
      case (pkt)
        3'd0:    p = c[31:24];
        3'd1:    p = c[23:16];
        3'd2:    p = c[15:8];
        3'd3:    p = c[7:0];
        3'd4:    p = {1'b0, flags, crc};
        default: p = 8'hFF;
      endcase
    end
    return p;
  endfunction

  function automatic logic pkt_bit_f(input logic [3:0] bit_idx, input logic typ, input logic [7:0] payload);
    logic       b;
    logic [2:0] idx;
    idx = 3'(4'd9 - bit_idx);
    case (bit_idx)
      4'd0:    b = 1'b0;
      4'd1:    b = typ;
      4'd10:   b = 1'b1;
      4'd11,
      4'd12,
      4'd13,
      4'd14,
      4'd15:   b = 1'b1;
      default: b = payload[idx];
    endcase
    return b;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    pkt_cnt_q, pkt_cnt_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
`ifdef MTM_SOUT_IDLE_GAP_EN
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif
  logic [31:0]   c_q, c_d;
  logic [3:0]    flags_q, flags_d;
  logic [2:0]    crc_q, crc_d;
  logic [2:0]    err_q, err_d;
  logic          is_err_q, is_err_d;
  logic          sout_q, sout_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  logic          accept_s;
  logic          bit_end_s;
  logic [2:0]    pkt_last_s;
  logic [7:0]    payload_s;

  // Next-state, counters and registered line/handshake outputs
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    clk_cnt_d  = clk_cnt_q;
`ifdef MTM_SOUT_IDLE_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    c_d        = c_q;
    flags_d    = flags_q;
    crc_d      = crc_q;
    err_d      = err_q;
    is_err_d   = is_err_q;
    accept_s   = in_if.in_valid && ready_q && PARAMS_OK;
    bit_end_s  = (clk_cnt_q == BIT_LAST);
    pkt_last_s = is_err_q ? 3'd0 : 3'd4;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d   = S_SEND;
          bit_cnt_d = 4'd0;
          pkt_cnt_d = 3'd0;
          clk_cnt_d = '0;
          c_d       = in_if.in_c;
          flags_d   = in_if.in_flags;
          crc_d     = crc3_f(in_if.in_c, in_if.in_flags);
          err_d     = in_if.in_err;
          is_err_d  = in_if.in_is_err;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (!bit_end_s) begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end else if (bit_cnt_q != 4'd10) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (pkt_cnt_q == pkt_last_s) begin
          clk_cnt_d = '0;
          bit_cnt_d = 4'd0;
          pkt_cnt_d = 3'd0;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = '0;
          bit_cnt_d = 4'd0;
          pkt_cnt_d = pkt_cnt_q + 3'd1;
`ifdef MTM_SOUT_IDLE_GAP_EN
          state_d   = (GAP_BITS > 0) ? S_GAP : S_SEND;
`else
          state_d   = S_SEND;
`endif
        end
      end
`ifdef MTM_SOUT_IDLE_GAP_EN
      S_GAP: begin
        if (!bit_end_s) begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end else if (gap_cnt_q == GAP_LAST) begin
          clk_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = S_SEND;
        end else begin
          clk_cnt_d = '0;
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level is derived from the next state so the start bit appears the cycle after accept
    payload_s = payload_f(is_err_d, pkt_cnt_d, c_d, flags_d, crc_d, err_d);
    if (state_d == S_SEND) begin
      sout_d = pkt_bit_f(bit_cnt_d, is_err_d || (pkt_cnt_d == 3'd4), payload_s);
    end else begin
      sout_d = 1'b1;
    end
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      pkt_cnt_q <= 3'd0;
      clk_cnt_q <= '0;
`ifdef MTM_SOUT_IDLE_GAP_EN
      gap_cnt_q <= '0;
`endif
      c_q       <= 32'd0;
      flags_q   <= 4'd0;
      crc_q     <= 3'd0;
      err_q     <= 3'd0;
      is_err_q  <= 1'b0;
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      clk_cnt_q <= clk_cnt_d;
`ifdef MTM_SOUT_IDLE_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
      c_q       <= c_d;
      flags_q   <= flags_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      is_err_q  <= is_err_d;
      sout_q    <= sout_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign sout           = sout_q;
  assign busy           = busy_q;
  assign in_if.in_ready = ready_q;
endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Randomized self-checking bench for mtm_alu_serializer; two instances (1 and 4 clocks per bit).
module tb_mtm_alu_serializer;
  localparam int GAP_BITS = 2;
`ifdef MTM_SOUT_IDLE_GAP_EN
  localparam int GAP_EN = 1;
`else
  localparam int GAP_EN = 0;
`endif

  logic        clk;
  logic        rst;
  logic        v_valid, v_is_err;
  logic [31:0] v_c;
  logic [3:0]  v_flags;
  logic [2:0]  v_err;
  bit          sel;
  logic        sout1, busy1, sout4, busy4;
  logic        o_sout, o_busy, o_ready;
  logic        obs_q[$];
  logic        exp_q[$];
  int          errors;
  int          checks;

  mtm_alu_serializer_if if1 ();
  mtm_alu_serializer_if if4 ();

  assign if1.in_valid  = v_valid & ~sel;
  assign if1.in_is_err = v_is_err;
  assign if1.in_c      = v_c;
  assign if1.in_flags  = v_flags;
  assign if1.in_err    = v_err;
  assign if4.in_valid  = v_valid & sel;
  assign if4.in_is_err = v_is_err;
  assign if4.in_c      = v_c;
  assign if4.in_flags  = v_flags;
  assign if4.in_err    = v_err;

  assign o_sout  = sel ? sout4 : sout1;
  assign o_busy  = sel ? busy4 : busy1;
  assign o_ready = sel ? if4.in_ready : if1.in_ready;

  mtm_alu_serializer #(.CLKS_PER_BIT(1), .GAP_BITS(GAP_BITS)) u_dut1 (
    .clk(clk), .rst(rst), .in_if(if1.slave), .sout(sout1), .busy(busy1));
  mtm_alu_serializer #(.CLKS_PER_BIT(4), .GAP_BITS(GAP_BITS)) u_dut4 (
    .clk(clk), .rst(rst), .in_if(if4.slave), .sout(sout4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Reference CRC by polynomial long division of msg*x^3 by 1011
  function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  task automatic build_exp(input logic is_err, input logic [31:0] c, input logic [3:0] f, input logic [2:0] e);
    logic [7:0] pl[$];
    logic       ty[$];
    logic [7:0] p;
    logic [10:0] bits;
    int         cp;
    cp = sel ? 4 : 1;
    exp_q.delete();
    if (is_err) begin
      p    = {1'b1, e, e, 1'b0};
      p[0] = ($countones(p[7:1]) % 2) == 1;
      pl.push_back(p);
      ty.push_back(1'b1);
    end else begin
      for (int k = 3; k >= 0; k--) begin
        pl.push_back(8'((c >> (8 * k)) & 32'hFF));
        ty.push_back(1'b0);
      end
      pl.push_back({1'b0, f, ref_crc(c, f)});
      ty.push_back(1'b1);
    end
    for (int k = 0; k < pl.size(); k++) begin
      bits = {1'b0, ty[k], pl[k], 1'b1};
      for (int j = 10; j >= 0; j--) repeat (cp) exp_q.push_back(bits[j]);
      if (GAP_EN != 0 && k < pl.size() - 1) repeat (GAP_BITS * cp) exp_q.push_back(1'b1);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] obs_byte(input int k);
    int         cp, base, idx;
    logic [7:0] b;
    cp   = sel ? 4 : 1;
    base = k * (11 + GAP_EN * GAP_BITS) * cp;
    b    = 8'h00;
    for (int j = 0; j < 8; j++) begin
      idx = base + (2 + j) * cp;
      if (idx < obs_q.size()) b[7 - j] = obs_q[idx];
    end
    return b;
  endfunction

  task automatic accept_word(input logic is_err, input logic [31:0] c, input logic [3:0] f,
                             input logic [2:0] e, input bit hold);
    int w;
    v_is_err = is_err; v_c = c; v_flags = f; v_err = e; v_valid = 1'b1;
    w = 0;
    while (o_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 2000) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", o_ready, w);
    end
    @(posedge clk);
    #1;
    if (hold) begin
      v_c = $urandom; v_flags = 4'($urandom); v_err = 3'($urandom); v_is_err = 1'($urandom);
    end else begin
      v_valid = 1'b0;
    end
  endtask

  task automatic capture_frame();
    int w;
    bit done;
    obs_q.delete();
    w = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (o_busy !== 1'b1) begin
        done = 1'b1;
      end else begin
        obs_q.push_back(o_sout);
        w++;
        if (w >= 3000) begin
          checks++; errors++;
          $display("FAIL frame_end: busy still %b after %0d cycles, required 0", o_busy, w);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    sel = 1'b0; v_valid = 1'b0; v_is_err = 1'b0; v_c = 32'd0; v_flags = 4'd0; v_err = 3'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sout1, busy1, if1.in_ready, sout4, busy4, if4.in_ready} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_hold: {sout,busy,ready}x2=%b, required 100100",
               {sout1, busy1, if1.in_ready, sout4, busy4, if4.in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sout1, busy1, if1.in_ready, sout4, busy4, if4.in_ready} !== 6'b101101) begin
      errors++;
      $display("FAIL reset_release: {sout,busy,ready}x2=%b, required 101101",
               {sout1, busy1, if1.in_ready, sout4, busy4, if4.in_ready});
    end
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (sout1 !== 1'b1 || busy1 !== 1'b0 || sout4 !== 1'b1 || busy4 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_line: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_zero_result();
    int d;
    sel = 1'b0;
    accept_word(1'b0, 32'h0000_0000, 4'b0100, 3'b000, 1'b0);
    capture_frame();
    build_exp(1'b0, 32'h0000_0000, 4'b0100, 3'b000);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL zero_stream: first diff at cycle %0d (got len %0d), required len %0d", d, obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_q.size() != 55 + 4 * GAP_BITS * GAP_EN) begin
      errors++;
      $display("FAIL zero_len: busy %0d cycles, required %0d", obs_q.size(), 55 + 4 * GAP_BITS * GAP_EN);
    end
    checks++;
    if (obs_byte(4) !== 8'h27) begin
      errors++;
      $display("FAIL zero_ctl: CTL=%h, required 27", obs_byte(4));
    end
  endtask

  task automatic test_error_frames();
    logic [2:0] errs[3] = '{3'b010, 3'b100, 3'b001};
    logic [7:0] want[3] = '{8'hA5, 8'hC9, 8'h93};
    int d;
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      accept_word(1'b1, $urandom, 4'($urandom), errs[i], 1'b0);
      capture_frame();
      build_exp(1'b1, 32'd0, 4'd0, errs[i]);
      d = first_diff();
      checks++;
      if (d >= 0 || obs_q.size() != 11 || obs_byte(0) !== want[i]) begin
        errors++;
        $display("FAIL err_frame_%b: byte=%h len=%0d diff=%0d, required byte %h len 11", errs[i], obs_byte(0), obs_q.size(), d, want[i]);
      end
    end
  endtask

  task automatic test_hold_deadbeef();
    logic        s_is_err;
    logic [31:0] s_c;
    logic [3:0]  s_f;
    logic [2:0]  s_e;
    logic [7:0]  ctl;
    int d;
    sel = 1'b0;
    accept_word(1'b0, 32'hDEAD_BEEF, 4'b0000, 3'b000, 1'b1);
    capture_frame();
    s_is_err = v_is_err; s_c = v_c; s_f = v_flags; s_e = v_err;
    build_exp(1'b0, 32'hDEAD_BEEF, 4'b0000, 3'b000);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL deadbeef_stream: first diff at cycle %0d, got len %0d, required len %0d", d, obs_q.size(), exp_q.size());
    end
    checks++;
    if ({obs_byte(0), obs_byte(1), obs_byte(2), obs_byte(3)} !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL deadbeef_data: %h, required deadbeef", {obs_byte(0), obs_byte(1), obs_byte(2), obs_byte(3)});
    end
    ctl = obs_byte(4);
    checks++;
    if (ctl !== {5'b00000, ref_crc(32'hDEAD_BEEF, 4'b0000)}) begin
      errors++;
      $display("FAIL deadbeef_ctl: %h, required %h", ctl, {5'b00000, ref_crc(32'hDEAD_BEEF, 4'b0000)});
    end
    @(posedge clk);
    #1;
    v_valid = 1'b0;
    capture_frame();
    build_exp(s_is_err, s_c, s_f, s_e);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL held_second_frame: first diff at cycle %0d, got len %0d, required len %0d", d, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_c, b_c;
    logic [3:0]  a_f, b_f;
    int d, flen;
    sel = 1'b1;
    a_c = $urandom; a_f = 4'($urandom); b_c = $urandom; b_f = 4'($urandom);
    flen = (55 + 4 * GAP_BITS * GAP_EN) * 4;
    accept_word(1'b0, a_c, a_f, 3'b000, 1'b1);
    capture_frame();
    checks++;
    if ({o_sout, o_busy, o_ready} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_idle_cycle: {sout,busy,ready}=%b, required 101", {o_sout, o_busy, o_ready});
    end
    v_is_err = 1'b0; v_c = b_c; v_flags = b_f; v_err = 3'b000;
    build_exp(1'b0, a_c, a_f, 3'b000);
    d = first_diff();
    checks++;
    if (d >= 0 || obs_q.size() != flen) begin
      errors++;
      $display("FAIL b2b_first: diff at %0d len %0d, required len %0d", d, obs_q.size(), flen);
    end
    @(posedge clk);
    #1;
    v_valid = 1'b0;
    capture_frame();
    build_exp(1'b0, b_c, b_f, 3'b000);
    d = first_diff();
    checks++;
    if (d >= 0 || obs_q.size() != flen) begin
      errors++;
      $display("FAIL b2b_second: diff at %0d len %0d, required len %0d", d, obs_q.size(), flen);
    end
  endtask

  task automatic test_random();
    logic        is_err;
    logic [31:0] c;
    logic [3:0]  f;
    logic [2:0]  e;
    int d;
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom); is_err = 1'($urandom); c = $urandom; f = 4'($urandom); e = 3'($urandom);
      accept_word(is_err, c, f, e, 1'b0);
      capture_frame();
      build_exp(is_err, c, f, e);
      d = first_diff();
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL random_%0d: sel=%0d err=%b c=%h f=%b e=%b diff at %0d len %0d, required len %0d",
                 i, sel, is_err, c, f, e, d, obs_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    sel = 1'b0;
    accept_word(1'b0, $urandom, 4'($urandom), 3'b000, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: busy=%b, required 1", busy1);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sout1, busy1} !== 2'b10) begin
      errors++;
      $display("FAIL midframe_abort: {sout,busy}=%b, required 10", {sout1, busy1});
    end
    rst = 1'b0;
    @(negedge clk);
    accept_word(1'b1, 32'd0, 4'd0, 3'b010, 1'b0);
    capture_frame();
    build_exp(1'b1, 32'd0, 4'd0, 3'b010);
    d = first_diff();
    checks++;
    if (d >= 0 || obs_byte(0) !== 8'hA5) begin
      errors++;
      $display("FAIL after_reset_err: byte=%h diff=%0d, required A5 and no diff", obs_byte(0), d);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_zero_result();
    test_error_frames();
    test_hold_deadbeef();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
